// File: rtl/axi4_lite_master_read_checker_pkg.sv
// Shared definitions for the AXI4-Lite master read-channel checker:
// error-bit indices, timestamp width and default protocol limits.
package axi4_lite_master_read_checker_pkg;

    // Width of the error vectors (one bit per violation class)
    localparam int ERR_W = 7;

    // Width of the free-running timestamp; all ages are taken modulo 2^TS_W
    localparam int TS_W = 16;

    // Default limits used by the read assertions and cover points
    localparam int DEF_MAX_DELAY_READY           = 16;
    localparam int DEF_MAX_DELAY_RVALID          = 10;
    localparam int DEF_DELAY_FOR_SECOND_TRANSFER = 16;
    localparam int DEF_MAX_OUTSTANDING           = 4;

    // Bit positions inside err_pulse / err_sticky
    typedef enum logic [2:0] {
        ERR_ARREADY_TIMEOUT      = 3'd0,
        ERR_RREADY_TIMEOUT       = 3'd1,
        ERR_RVALID_LATENCY       = 3'd2,
        ERR_AR_UNSTABLE          = 3'd3,
        ERR_R_UNSTABLE           = 3'd4,
        ERR_R_UNEXPECTED         = 3'd5,
        ERR_OUTSTANDING_OVERFLOW = 3'd6
    } err_idx_e;

    // Age of a stored timestamp relative to the current one, wrapping modulo 2^TS_W
    function automatic logic [TS_W-1:0] ts_diff(input logic [TS_W-1:0] now_ts,
                                                input logic [TS_W-1:0] past_ts);
        return now_ts - past_ts;
    endfunction

endpackage

// File: rtl/axi4_lite_read_ts_fifo.sv
// Small circular FIFO of {timestamp, flagged} entries, one per outstanding
// AR handshake. Pushes are dropped when full unless a pop happens in the
// same cycle; pops are ignored when empty. The flag of the head entry can be
// set so a late response is only reported once.
module axi4_lite_read_ts_fifo
    import axi4_lite_master_read_checker_pkg::*;
#(
    parameter int DEPTH = DEF_MAX_OUTSTANDING
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic                         push,
    input  logic [TS_W-1:0]              push_ts,
    input  logic                         pop,
    input  logic                         set_flag,
    output logic [TS_W-1:0]              head_ts,
    output logic                         head_flagged,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [TS_W-1:0]  ts_mem   [DEPTH];
    logic             flag_mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign full         = (cnt == CNT_FULL);
    assign empty        = (cnt == '0);
    assign count        = cnt;
    assign head_ts      = ts_mem[rd_ptr];
    assign head_flagged = flag_mem[rd_ptr];
    assign do_pop       = pop & ~empty;
    assign do_push      = push & (~full | do_pop);

    // Storage, pointers and occupancy; a push into the slot being popped
    // overwrites the head flag so a fresh entry always starts unflagged
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ts_mem[i]   <= '0;
                flag_mem[i] <= 1'b0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (set_flag && !empty) begin
                flag_mem[rd_ptr] <= 1'b1;
            end
            if (do_push) begin
                ts_mem[wr_ptr]   <= push_ts;
                flag_mem[wr_ptr] <= 1'b0;
                wr_ptr           <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (do_push && !do_pop) begin
                cnt <= cnt + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/axi4_lite_master_read_checker.sv
// Passive checker for the AXI4-Lite master read channels (AR, R).
// Watches handshake stalls, AR-to-RVALID latency, payload stability and the
// number of outstanding reads, reporting violations as one-cycle pulses and
// as sticky bits. Coverage counters are built only when the macro
// AXI4LITE_MASTER_READ_COVER_EN is defined; otherwise they read as zero.
module axi4_lite_master_read_checker
    import axi4_lite_master_read_checker_pkg::*;
#(
    parameter int ADDR_WIDTH                = 32,
    parameter int DATA_WIDTH                = 32,
    parameter int MAX_DELAY_READY           = DEF_MAX_DELAY_READY,
    parameter int MAX_DELAY_RVALID          = DEF_MAX_DELAY_RVALID,
    parameter int DELAY_FOR_SECOND_TRANSFER = DEF_DELAY_FOR_SECOND_TRANSFER,
    parameter int MAX_OUTSTANDING           = DEF_MAX_OUTSTANDING
) (
    input  logic                                 aclk,
    input  logic                                 areset,
    input  logic                                 arvalid,
    input  logic                                 arready,
    input  logic [ADDR_WIDTH-1:0]                araddr,
    input  logic [2:0]                           arprot,
    input  logic                                 rvalid,
    input  logic                                 rready,
    input  logic [DATA_WIDTH-1:0]                rdata,
    input  logic [1:0]                           rresp,
    input  logic                                 err_clear,
    output logic [ERR_W-1:0]                     err_pulse,
    output logic [ERR_W-1:0]                     err_sticky,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
    output logic [15:0]                          cov_b2b_count,
    output logic [15:0]                          cov_max_latency
);

    localparam int STALL_W = $clog2(MAX_DELAY_READY + 2);
    localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(MAX_DELAY_READY);
    localparam logic [STALL_W-1:0] STALL_SAT   = STALL_W'(MAX_DELAY_READY + 1);
    localparam logic [TS_W-1:0]    LAT_LIMIT   = TS_W'(MAX_DELAY_RVALID);

    logic                  ar_hs;
    logic                  r_hs;
    logic                  ar_stall;
    logic                  r_stall;
    logic [STALL_W-1:0]    ar_stall_cnt;
    logic [STALL_W-1:0]    r_stall_cnt;
    logic                  ar_prev_stall;
    logic                  r_prev_stall;
    logic [ADDR_WIDTH-1:0] ar_prev_addr;
    logic [2:0]            ar_prev_prot;
    logic [DATA_WIDTH-1:0] r_prev_data;
    logic [1:0]            r_prev_resp;
    logic [TS_W-1:0]       ts_now;
    logic [TS_W-1:0]       head_ts;
    logic [TS_W-1:0]       age;
    logic                  head_flagged;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  first_rvalid;
    logic                  pop_ok;
    logic                  lat_late;
    logic                  hang;
    logic                  set_flag;
    logic [ERR_W-1:0]      err_now;

    assign ar_hs        = arvalid & arready;
    assign r_hs         = rvalid & rready;
    assign ar_stall     = arvalid & ~arready;
    assign r_stall      = rvalid & ~rready;
    assign first_rvalid = rvalid & ~r_prev_stall;
    assign pop_ok       = r_hs & ~fifo_empty;
    assign age          = ts_diff(ts_now, head_ts);
    assign lat_late     = first_rvalid & ~fifo_empty & ~head_flagged & (age > LAT_LIMIT);
    assign hang         = ~rvalid & ~fifo_empty & ~head_flagged & (age > LAT_LIMIT);
    assign set_flag     = lat_late | hang;

    axi4_lite_read_ts_fifo #(
        .DEPTH        (MAX_OUTSTANDING)
    ) u_ts_fifo (
        .aclk         (aclk),
        .areset       (areset),
        .push         (ar_hs),
        .push_ts      (ts_now),
        .pop          (r_hs),
        .set_flag     (set_flag),
        .head_ts      (head_ts),
        .head_flagged (head_flagged),
        .count        (outstanding),
        .full         (fifo_full),
        .empty        (fifo_empty)
    );

    // Free-running timestamp used to age every outstanding read
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            ts_now <= '0;
        end else begin
            ts_now <= ts_now + TS_W'(1);
        end
    end

    // Stall run lengths (saturating one past the limit so a long stall is reported once)
    // and last-cycle channel state for the stability checks
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            ar_stall_cnt  <= '0;
            r_stall_cnt   <= '0;
            ar_prev_stall <= 1'b0;
            r_prev_stall  <= 1'b0;
            ar_prev_addr  <= '0;
            ar_prev_prot  <= '0;
            r_prev_data   <= '0;
            r_prev_resp   <= '0;
        end else begin
            if (!ar_stall) begin
                ar_stall_cnt <= '0;
            end else if (ar_stall_cnt != STALL_SAT) begin
                ar_stall_cnt <= ar_stall_cnt + STALL_W'(1);
            end
            if (!r_stall) begin
                r_stall_cnt <= '0;
            end else if (r_stall_cnt != STALL_SAT) begin
                r_stall_cnt <= r_stall_cnt + STALL_W'(1);
            end
            ar_prev_stall <= ar_stall;
            r_prev_stall  <= r_stall;
            ar_prev_addr  <= araddr;
            ar_prev_prot  <= arprot;
            r_prev_data   <= rdata;
            r_prev_resp   <= rresp;
        end
    end

    // Violations detected in the current cycle
    always_comb begin
        err_now = '0;
        err_now[ERR_ARREADY_TIMEOUT]      = ar_stall & (ar_stall_cnt == STALL_LIMIT);
        err_now[ERR_RREADY_TIMEOUT]       = r_stall & (r_stall_cnt == STALL_LIMIT);
        err_now[ERR_RVALID_LATENCY]       = lat_late | hang;
        err_now[ERR_AR_UNSTABLE]          = ar_prev_stall &
                                            (~arvalid | (araddr != ar_prev_addr) | (arprot != ar_prev_prot));
        err_now[ERR_R_UNSTABLE]           = r_prev_stall &
                                            (~rvalid | (rdata != r_prev_data) | (rresp != r_prev_resp));
        err_now[ERR_R_UNEXPECTED]         = first_rvalid & fifo_empty;
        err_now[ERR_OUTSTANDING_OVERFLOW] = ar_hs & fifo_full & ~pop_ok;
    end

    // Registered error reporting; a violation seen during a clear is kept
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            err_pulse  <= '0;
            err_sticky <= '0;
        end else begin
            err_pulse  <= err_now;
            err_sticky <= err_clear ? err_now : (err_sticky | err_now);
        end
    end

`ifdef AXI4LITE_MASTER_READ_COVER_EN
    localparam int GAP_W = $clog2(DELAY_FOR_SECOND_TRANSFER + 2);
    localparam logic [GAP_W-1:0] GAP_SAT = GAP_W'(DELAY_FOR_SECOND_TRANSFER + 1);

    logic [GAP_W-1:0] gap_cnt;
    logic             have_prev_ar;

    // Back-to-back AR counting (gap saturates once it exceeds the window) and
    // running maximum of measured AR-to-RVALID latencies
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            gap_cnt         <= '0;
            have_prev_ar    <= 1'b0;
            cov_b2b_count   <= '0;
            cov_max_latency <= '0;
        end else begin
            if (ar_hs) begin
                if (have_prev_ar && (gap_cnt != GAP_SAT) && (cov_b2b_count != 16'hFFFF)) begin
                    cov_b2b_count <= cov_b2b_count + 16'd1;
                end
                gap_cnt      <= GAP_W'(1);
                have_prev_ar <= 1'b1;
            end else if (gap_cnt != GAP_SAT) begin
                gap_cnt <= gap_cnt + GAP_W'(1);
            end
            if (first_rvalid && !fifo_empty && (age > cov_max_latency)) begin
                cov_max_latency <= age;
            end
        end
    end
`else
    logic [TS_W-1:0] unused_cov_window;

    assign unused_cov_window = TS_W'(DELAY_FOR_SECOND_TRANSFER);
    assign cov_b2b_count     = '0;
    assign cov_max_latency   = '0;
`endif

endmodule

// File: tb/tb_axi4_lite_master_read_checker.sv
// Self-checking bench for axi4_lite_master_read_checker. A transaction-level
// model (queue of pending read issue cycles, stall run lengths) predicts the
// outputs every cycle; directed sequences add literal expectations.
// Build with or without AXI4LITE_MASTER_READ_COVER_EN.
module tb_axi4_lite_master_read_checker;
    import axi4_lite_master_read_checker_pkg::*;

    localparam int ADDR_WIDTH       = 32;
    localparam int DATA_WIDTH       = 32;
    localparam int MAX_READY        = 16;
    localparam int MAX_RVALID       = 10;
    localparam int B2B_WINDOW       = 16;
    localparam int MAX_OUT          = 4;
    localparam int OUT_W            = $clog2(MAX_OUT + 1);

    logic                  aclk;
    logic                  areset;
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  err_clear;
    logic [ERR_W-1:0]      err_pulse;
    logic [ERR_W-1:0]      err_sticky;
    logic [OUT_W-1:0]      outstanding;
    logic [15:0]           cov_b2b_count;
    logic [15:0]           cov_max_latency;

    int total = 0;
    int bad   = 0;

    axi4_lite_master_read_checker #(
        .ADDR_WIDTH                (ADDR_WIDTH),
        .DATA_WIDTH                (DATA_WIDTH),
        .MAX_DELAY_READY           (MAX_READY),
        .MAX_DELAY_RVALID          (MAX_RVALID),
        .DELAY_FOR_SECOND_TRANSFER (B2B_WINDOW),
        .MAX_OUTSTANDING           (MAX_OUT)
    ) dut (
        .aclk            (aclk),
        .areset          (areset),
        .arvalid         (arvalid),
        .arready         (arready),
        .araddr          (araddr),
        .arprot          (arprot),
        .rvalid          (rvalid),
        .rready          (rready),
        .rdata           (rdata),
        .rresp           (rresp),
        .err_clear       (err_clear),
        .err_pulse       (err_pulse),
        .err_sticky      (err_sticky),
        .outstanding     (outstanding),
        .cov_b2b_count   (cov_b2b_count),
        .cov_max_latency (cov_max_latency)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // ---------------- transaction-level model ----------------
    typedef struct {
        int issue;
        bit flagged;
    } pend_t;

    pend_t                 pend[$];
    int                    cyc;
    int                    ar_run;
    int                    r_run;
    int                    last_ar;
    bit                    m_ar_prev_stall;
    bit                    m_r_prev_stall;
    logic [ADDR_WIDTH-1:0] m_prev_addr;
    logic [2:0]            m_prev_prot;
    logic [DATA_WIDTH-1:0] m_prev_data;
    logic [1:0]            m_prev_resp;
    logic [ERR_W-1:0]      exp_pulse;
    logic [ERR_W-1:0]      exp_sticky;
    int                    exp_out;
    int                    exp_b2b;
    int                    exp_max_lat;

    task automatic model_reset();
        pend.delete();
        cyc             = 0;
        ar_run          = 0;
        r_run           = 0;
        last_ar         = -1;
        m_ar_prev_stall = 0;
        m_r_prev_stall  = 0;
        m_prev_addr     = '0;
        m_prev_prot     = '0;
        m_prev_data     = '0;
        m_prev_resp     = '0;
        exp_pulse       = '0;
        exp_sticky      = '0;
        exp_out         = 0;
        exp_b2b         = 0;
        exp_max_lat     = 0;
    endtask

    task automatic model_step();
        logic [ERR_W-1:0] err;
        bit    ar_st;
        bit    r_st;
        bit    popped;
        int    size0;
        int    lat;
        pend_t head;
        pend_t entry;
        err    = '0;
        ar_st  = arvalid && !arready;
        r_st   = rvalid && !rready;
        popped = 0;
        size0  = pend.size();

        ar_run = ar_st ? ar_run + 1 : 0;
        r_run  = r_st ? r_run + 1 : 0;
        if (ar_run == MAX_READY + 1) err[0] = 1'b1;
        if (r_run == MAX_READY + 1) err[1] = 1'b1;

        if (m_ar_prev_stall && (!arvalid || araddr != m_prev_addr || arprot != m_prev_prot)) err[3] = 1'b1;
        if (m_r_prev_stall && (!rvalid || rdata != m_prev_data || rresp != m_prev_resp)) err[4] = 1'b1;

        if (size0 > 0) head = pend[0];
        if (rvalid && !m_r_prev_stall) begin
            if (size0 == 0) begin
                err[5] = 1'b1;
            end else begin
                lat = cyc - head.issue;
                if (lat > exp_max_lat) exp_max_lat = lat;
                if (lat > MAX_RVALID && !head.flagged) begin
                    err[2] = 1'b1;
                    head.flagged = 1'b1;
                    pend[0] = head;
                end
            end
        end else if (!rvalid && size0 > 0 && !head.flagged && (cyc - head.issue) > MAX_RVALID) begin
            err[2] = 1'b1;
            head.flagged = 1'b1;
            pend[0] = head;
        end

        if (rvalid && rready && size0 > 0) begin
            void'(pend.pop_front());
            popped = 1;
        end
        if (arvalid && arready) begin
            if (size0 == MAX_OUT && !popped) begin
                err[6] = 1'b1;
            end else begin
                entry.issue   = cyc;
                entry.flagged = 1'b0;
                pend.push_back(entry);
            end
            if (last_ar >= 0 && (cyc - last_ar) <= B2B_WINDOW && exp_b2b < 65535) exp_b2b++;
            last_ar = cyc;
        end

        m_ar_prev_stall = ar_st;
        m_r_prev_stall  = r_st;
        m_prev_addr     = araddr;
        m_prev_prot     = arprot;
        m_prev_data     = rdata;
        m_prev_resp     = rresp;
        exp_sticky      = err_clear ? err : (exp_sticky | err);
        exp_pulse       = err;
        exp_out         = pend.size();
        cyc++;
    endtask

    // Model advances on every sampling edge, and restarts on reset
    always @(posedge aclk or posedge areset) begin
        if (areset) model_reset();
        else        model_step();
    end

    task automatic check_output(input string name, input longint actual, input longint expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare every output against the model away from the sampling edge
    always @(negedge aclk) begin
        if (!areset) begin
            check_output("model_err_pulse", err_pulse, exp_pulse);
            check_output("model_err_sticky", err_sticky, exp_sticky);
            check_output("model_outstanding", outstanding, exp_out);
`ifdef AXI4LITE_MASTER_READ_COVER_EN
            check_output("model_cov_b2b", cov_b2b_count, exp_b2b);
            check_output("model_cov_max_lat", cov_max_latency, exp_max_lat);
`else
            check_output("model_cov_b2b_off", cov_b2b_count, 0);
            check_output("model_cov_max_lat_off", cov_max_latency, 0);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic apply_stimulus(input logic arv, input logic arr, input logic [31:0] addr,
                                  input logic rv, input logic rr, input logic [31:0] data,
                                  input logic clr);
        arvalid   = arv;
        arready   = arr;
        araddr    = addr;
        arprot    = 3'b010;
        rvalid    = rv;
        rready    = rr;
        rdata     = data;
        rresp     = 2'b00;
        err_clear = clr;
        @(negedge aclk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic ar(input logic [31:0] addr);
        apply_stimulus(1'b1, 1'b1, addr, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic rsp(input logic [31:0] data);
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, data, 1'b0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 100000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        areset    = 1'b1;
        arvalid   = 1'b0;
        arready   = 1'b0;
        araddr    = '0;
        arprot    = '0;
        rvalid    = 1'b0;
        rready    = 1'b0;
        rdata     = '0;
        rresp     = '0;
        err_clear = 1'b0;
        repeat (2) @(negedge aclk);
        check_output("reset_err_pulse", err_pulse, 0);
        check_output("reset_outstanding", outstanding, 0);
        areset = 1'b0;
        idle(2);

        // AR stalled exactly 16 cycles is legal
        for (int i = 0; i < 16; i++) apply_stimulus(1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
        check_output("ar_stall16_pulse", err_pulse, 0);
        ar(32'h100);
        check_output("ar_stall16_hs", err_pulse, 0);
        rsp(32'h1);
        idle(1);
        // 17 stall cycles times out
        for (int i = 0; i < 17; i++) apply_stimulus(1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
        check_output("ar_stall17_pulse", err_pulse, 7'h01);
        check_output("ar_stall17_sticky", err_sticky, 7'h01);
        ar(32'h100);
        check_output("ar_stall17_once", err_pulse, 0);
        rsp(32'h2);
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        check_output("clear_sticky_1", err_sticky, 0);

        // RVALID latency 10 legal, 11 flagged once
        ar(32'h200);
        idle(9);
        rsp(32'h5);
        check_output("lat10_pulse", err_pulse, 0);
        ar(32'h204);
        idle(10);
        rsp(32'h6);
        check_output("lat11_pulse", err_pulse, 7'h04);
        idle(1);
        check_output("lat11_once", err_pulse, 0);
`ifdef AXI4LITE_MASTER_READ_COVER_EN
        check_output("cov_max_lat_11", cov_max_latency, 11);
`endif

        // Payload stability on AR and R
        apply_stimulus(1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 32'h104, 1'b0, 1'b0, 32'h0, 1'b0);
        check_output("ar_unstable", err_pulse, 7'h08);
        ar(32'h104);
        check_output("ar_stable_hs", err_pulse, 0);
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'hAA, 1'b0);
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        check_output("r_unstable", err_pulse, 7'h10);
        rsp(32'hAA);
        check_output("r_drop_done_out", outstanding, 0);

        // Outstanding limit
        for (int i = 0; i < 4; i++) ar(32'h300 + 32'(4 * i));
        check_output("out_four", outstanding, 4);
        ar(32'h310);
        check_output("overflow_pulse", err_pulse, 7'h40);
        check_output("overflow_out", outstanding, 4);
        apply_stimulus(1'b1, 1'b1, 32'h314, 1'b1, 1'b1, 32'h1, 1'b0);
        check_output("full_push_pop_pulse", err_pulse, 0);
        check_output("full_push_pop_out", outstanding, 4);
        for (int i = 0; i < 4; i++) rsp(32'h10 + 32'(i));
        check_output("drain_out", outstanding, 0);
        check_output("drain_pulse", err_pulse, 0);

        // Unexpected response, then clear
        rsp(32'h55);
        check_output("r_unexpected", err_pulse, 7'h20);
        check_output("r_unexpected_out", outstanding, 0);
        check_output("sticky_accum", err_sticky, 7'h7C);
        apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        check_output("clear_sticky_2", err_sticky, 0);

        // Reset with reads in flight
        for (int i = 0; i < 3; i++) ar(32'h400 + 32'(4 * i));
        check_output("inflight_out", outstanding, 3);
        apply_stimulus(1'b1, 1'b0, 32'h500, 1'b0, 1'b0, 32'h0, 1'b0);
        idle(1);
        check_output("pre_reset_pulse", err_pulse, 7'h08);
        #2 areset = 1'b1;
        #1;
        check_output("async_reset_pulse", err_pulse, 0);
        check_output("async_reset_sticky", err_sticky, 0);
        check_output("async_reset_out", outstanding, 0);
        check_output("async_reset_b2b", cov_b2b_count, 0);
        check_output("async_reset_lat", cov_max_latency, 0);
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            idle(1);
            check_output("post_reset_quiet", err_pulse, 0);
        end
        ar(32'h600);
        idle(4);
        ar(32'h604);
`ifdef AXI4LITE_MASTER_READ_COVER_EN
        check_output("cov_b2b_one", cov_b2b_count, 1);
`endif
        rsp(32'h7);
        rsp(32'h8);
        idle(2);
        check_output("final_out", outstanding, 0);
        check_output("final_sticky", err_sticky, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
